// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, single-entry valid/ready output buffer.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int unsigned SYSTEM_CLK     = 50000000,
    parameter int unsigned UART_BUAD_RATE = 9600
) (
    input  logic       i_sys_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_parity_err
);

    localparam int unsigned DF = SYSTEM_CLK / UART_BUAD_RATE;
    localparam int unsigned HF = DF / 2;
    localparam int unsigned CW = (DF > 1) ? $clog2(DF) : 1;
    localparam logic [CW-1:0] DF_LAST = CW'(DF - 1);
    localparam logic [CW-1:0] HF_LAST = CW'(HF - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } state_e;

    logic          sync1_q, sync2_q, prev_q;
    logic          rx_s;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          done_c;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_q, par_bad_d;
    logic          parity_err_q, parity_err_d;
`endif

    assign rx_s = sync2_q;

    // Synchronizer plus edge-detect history; all held at idle-high in reset
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= i_uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Frame FSM: next state, bit timing and error detection
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        done_c      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (prev_q && !rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == DF_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == DF_LAST) begin
                    cnt_d        = '0;
                    par_bad_d    = (rx_s != ^shift_q);
                    parity_err_d = (rx_s != ^shift_q);
                    state_d      = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == DF_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                    end else begin
`ifdef UART_RX_PARITY_EN
                        done_c = !par_bad_q;
`else
                        done_c = 1'b1;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output buffer: handshake drains it; a completion into a full, unaccepted buffer is an overrun
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (valid_q && i_rx_ready) begin
            valid_d = 1'b0;
        end
        if (done_c) begin
            if (!valid_q || i_rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign o_rx_data   = data_q;
    assign o_rx_valid  = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parity_err_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule
